// File: rtl/sw_debounce.sv
// Per-bit slide-switch debouncer: 2-flop synchronizer followed by a stable-run filter.
// Define SW_DEBOUNCE_EDGE_EN to build the per-bit sw_rise/sw_fall pulse outputs.
module sw_debounce #(
  parameter int WIDTH         = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw,
  output logic             changed
`ifdef SW_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
`endif
);

  localparam int            CW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]         r_s1;
  logic [WIDTH-1:0]         r_s2;
  logic [WIDTH-1:0]         r_sw;
  logic                     r_changed;
  logic [WIDTH-1:0][CW-1:0] r_cnt;
  logic [WIDTH-1:0][CW-1:0] w_cntNext;
  logic [WIDTH-1:0]         w_swNext;
  logic                     w_anyUpdate;

  // A bit is accepted only after its synchronized level has disagreed with sw for
  // STABLE_CYCLES consecutive edges; any agreement in between throws the run away.
  always_comb begin
    w_swNext  = r_sw;
    w_cntNext = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_s2[i] != r_sw[i]) begin
        if (r_cnt[i] == LAST) begin
          w_swNext[i] = r_s2[i];
        end else begin
          w_cntNext[i] = r_cnt[i] + CW'(1);
        end
      end
    end
    w_anyUpdate = (w_swNext != r_sw);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_sw      <= '0;
      r_cnt     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_s1      <= sw_raw;
      r_s2      <= r_s1;
      r_sw      <= w_swNext;
      r_cnt     <= w_cntNext;
      r_changed <= w_anyUpdate;
    end
  end

  assign sw      = r_sw;
  assign changed = r_changed;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  // Edge pulses are registered on the same edge as sw so they line up with changed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_swNext & ~r_sw;
      r_fall <= ~w_swNext & r_sw;
    end
  end

  assign sw_rise = r_rise;
  assign sw_fall = r_fall;
`else
  // Edge outputs are not built in this configuration.
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: directed scenarios with literal expectations
// plus a timestamp-based behavioural model compared on every cycle.
module tb_sw_debounce;

  localparam int W = 6;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw;
  logic         changed;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;

  always #5 clk = ~clk;

  sw_debounce #(
    .WIDTH(W),
    .STABLE_CYCLES(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_raw(sw_raw),
    .sw(sw),
    .changed(changed)
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
`endif
  );

`ifndef SW_DEBOUNCE_EDGE_EN
  assign sw_rise = '0;
  assign sw_fall = '0;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: each bit remembers the last edge at which it agreed with sw (or was
  // updated / reset); a bit flips once S edges have passed without agreement.
  int           edgeN = 0;
  bit           modelLive = 1'b0;
  logic [W-1:0] mS1, mS2, mSw, mRise, mFall;
  logic         mChg;
  int           mMark[W];

  // Literal expectations posted by the stimulus process for the next falling edge.
  bit           litValid = 1'b0;
  string        litName;
  logic [W-1:0] litSw, litRise, litFall;
  logic         litChg;

  initial begin : model
    logic [W-1:0] nSw;
    forever begin
      @(posedge clk);
      edgeN++;
      if (rst) begin
        mS1 = '0; mS2 = '0; mSw = '0; mRise = '0; mFall = '0; mChg = 1'b0;
        for (int i = 0; i < W; i++) mMark[i] = edgeN;
        modelLive = 1'b1;
      end else begin
        nSw = mSw;
        for (int i = 0; i < W; i++) begin
          if (mS2[i] == mSw[i]) begin
            mMark[i] = edgeN;
          end else if (edgeN - mMark[i] >= S) begin
            nSw[i]   = mS2[i];
            mMark[i] = edgeN;
          end
        end
        mRise = nSw & ~mSw;
        mFall = ~nSw & mSw;
        mChg  = (nSw != mSw);
        mS2   = mS1;
        mS1   = sw_raw;
        mSw   = nSw;
      end
    end
  end

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %b expected %b", name, edgeN, act, exp);
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      if (modelLive) begin
        cmp("model_sw", sw, mSw);
        cmp("model_changed", {{(W-1){1'b0}}, changed}, {{(W-1){1'b0}}, mChg});
`ifdef SW_DEBOUNCE_EDGE_EN
        cmp("model_rise", sw_rise, mRise);
        cmp("model_fall", sw_fall, mFall);
`endif
      end
      if (litValid) begin
        cmp({litName, "_sw"}, sw, litSw);
        cmp({litName, "_changed"}, {{(W-1){1'b0}}, changed}, {{(W-1){1'b0}}, litChg});
`ifdef SW_DEBOUNCE_EDGE_EN
        cmp({litName, "_rise"}, sw_rise, litRise);
        cmp({litName, "_fall"}, sw_fall, litFall);
`endif
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] raw, input logic r);
    sw_raw = raw;
    rst    = r;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] eSw, input logic eChg,
                             input logic [W-1:0] eRise, input logic [W-1:0] eFall);
    litName  = name;
    litSw    = eSw;
    litChg   = eChg;
    litRise  = eRise;
    litFall  = eFall;
    litValid = 1'b1;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
    litValid = 1'b0;
  endtask

  initial begin : stimulus
    applyStimulus(6'b111111, 1'b1);

    for (int k = 1; k <= 3; k++) begin
      nextEdge();
      checkOutput("reset", 6'b000000, 1'b0, 6'b000000, 6'b000000);
    end
    applyStimulus(6'b111111, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      nextEdge();
      checkOutput("release", (k >= 6) ? 6'b111111 : 6'b000000, (k == 6),
                  (k == 6) ? 6'b111111 : 6'b000000, 6'b000000);
    end

    applyStimulus(6'b000000, 1'b0);
    repeat (8) nextEdge();
    applyStimulus(6'b010001, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      nextEdge();
      checkOutput("step", (k >= 6) ? 6'b010001 : 6'b000000, (k == 6),
                  (k == 6) ? 6'b010001 : 6'b000000, 6'b000000);
    end

    applyStimulus(6'b000000, 1'b0);
    repeat (8) nextEdge();
    applyStimulus(6'b000001, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      nextEdge();
      checkOutput("glitch", 6'b000000, 1'b0, 6'b000000, 6'b000000);
      if (k == 3) applyStimulus(6'b000000, 1'b0);
    end

    // Bit 5 sampled as 1,0,1,1,1,1 then held: only the last 4-edge run counts.
    applyStimulus(6'b100000, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      nextEdge();
      checkOutput("bounce", (k >= 8) ? 6'b100000 : 6'b000000, (k == 8),
                  (k == 8) ? 6'b100000 : 6'b000000, 6'b000000);
      applyStimulus((k + 1 == 2) ? 6'b000000 : 6'b100000, 1'b0);
    end

    applyStimulus(6'b111111, 1'b0);
    repeat (8) nextEdge();
    applyStimulus(6'b110111, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      nextEdge();
      checkOutput("midrst", (k <= 4) ? 6'b111111 : ((k >= 11) ? 6'b110111 : 6'b000000),
                  (k == 11), (k == 11) ? 6'b110111 : 6'b000000, 6'b000000);
      applyStimulus(6'b110111, (k == 4));
    end

    applyStimulus(6'b001111, 1'b0);
    repeat (8) nextEdge();
    applyStimulus(6'b110000, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      nextEdge();
      checkOutput("allbits", (k >= 6) ? 6'b110000 : 6'b001111, (k == 6),
                  (k == 6) ? 6'b110000 : 6'b000000, (k == 6) ? 6'b001111 : 6'b000000);
    end

    // Independent random bouncing on all bits with occasional resets.
    for (int n = 0; n < 300; n++) begin
      nextEdge();
      applyStimulus(sw_raw ^ W'($urandom & $urandom & $urandom), ($urandom_range(63) == 0));
    end
    applyStimulus(sw_raw, 1'b0);
    repeat (10) nextEdge();

    nextEdge();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 6, number of switch bits; full width drives the 6-bit sw bus of the downstream 4-to-1 mux stage.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, number of consecutive cycles a synchronized bit must differ before being accepted; legal range 1..2^24.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port sw_raw  input  WIDTH  raw asynchronous slide-switch levels.
REQ-006 SHALL have port sw  output  WIDTH  debounced, registered switch levels.
REQ-007 SHALL have port changed  output  1  one-cycle pulse: at least one sw bit updated this cycle.
REQ-008 SHALL, with SW_DEBOUNCE_EDGE_EN defined, add ports sw_rise and sw_fall, each  output  WIDTH, per-bit one-cycle edge pulses.

Function
REQ-009 SHALL pass each sw_raw bit through a 2-flop synchronizer (s1, s2) before any other use.
REQ-010 SHALL keep one independent counter per bit, wide enough for STABLE_CYCLES-1, minimum 1 bit.
REQ-011 SHALL, per bit, per cycle: s2==sw -> counter cleared to 0; s2!=sw and counter<STABLE_CYCLES-1 -> counter+1; s2!=sw and counter==STABLE_CYCLES-1 -> sw takes s2, counter cleared to 0.
REQ-012 SHALL make a clean sw_raw step visible on sw exactly STABLE_CYCLES+2 rising edges after the first edge that samples it (2 sync + STABLE_CYCLES filter).
REQ-013 SHALL discard any s2 deviation lasting fewer than STABLE_CYCLES cycles: sw unchanged, counter back to 0.
REQ-014 SHALL restart the count from 0 whenever s2 returns to sw mid-count (bounce); no partial credit kept.
REQ-015 SHALL register changed in the same edge as the sw update it reports, so changed is high in exactly the cycle sw first shows the new value.
REQ-016 SHALL produce a single one-cycle changed pulse when several bits update on the same edge.
REQ-017 SHALL handle bits fully independently; a bouncing bit never delays or resets another bit's counter.
REQ-018 SHALL never let sw toggle more than once per STABLE_CYCLES cycles per bit.

Reset
REQ-019 SHALL, while rst is high at a rising edge, clear s1, s2, sw, all counters, changed, and (if compiled) sw_rise, sw_fall to 0.
REQ-020 SHALL give rst priority over every other update, including an update due on the same edge.
REQ-021 SHALL, on rst asserted mid-count, abandon the count; after release a held-high sw_raw bit reappears on sw after the full STABLE_CYCLES+2 edges.

Configuration
REQ-022 SHALL compile edge outputs only when macro SW_DEBOUNCE_EDGE_EN is defined: sw_rise[i] high for the one cycle sw[i] goes 0->1, sw_fall[i] high for the one cycle sw[i] goes 1->0, both aligned with changed.
REQ-023 SHALL, without SW_DEBOUNCE_EDGE_EN, omit sw_rise/sw_fall ports and their registers entirely; all other behaviour identical.

Verification (STABLE_CYCLES=4, WIDTH=6)
REQ-024 SHALL cover: rst held 3 cycles with sw_raw=6'b111111 -> sw=0, changed=0 throughout reset; released, sw=6'b111111 after 6 edges with one changed pulse.
REQ-025 SHALL cover: sw_raw 6'b000000 -> 6'b010001 held -> sw=6'b010001 on 6th edge, changed high that cycle only; sw_rise=6'b010001 when macro defined.
REQ-026 SHALL cover: sw_raw bit 0 high for 3 cycles then low -> sw stays 6'b000000, changed never asserts.
REQ-027 SHALL cover: bit 5 bounces 1,0,1,1,1,1 per cycle -> sw[5] set only after the final 4-cycle stable run, exactly one changed pulse.
REQ-028 SHALL cover: sw=6'b111111, rst pulsed 1 cycle at count 2 of a 1->0 transition on bit 3 -> all outputs 0 next cycle, sw returns to 6'b110111 after 6 edges.
REQ-029 SHALL cover: sw=6'b001111, sw_raw -> 6'b110000 on one edge -> all six bits update same cycle, single changed pulse, sw_fall=6'b001111 and sw_rise=6'b110000 with macro.
